// File: rtl/banzai_infer_sched.sv
// banzAI inference scheduler: powers the machine array up, loads one command's observations,
// starts the machine, collects the result (or a timeout), returns it, then powers the array down.
module banzai_infer_sched #(
   parameter int          N_OBS          = 4,
   parameter int          OBS_W          = 8,
   parameter int          RES_W          = 16,
   parameter int          TIMEOUT        = 1024,
   parameter logic [15:0] INF_COUNT_INIT = 16'h0000
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cmd_valid,
   output logic                                   cmd_ready,
   input  logic [N_OBS*OBS_W-1:0]                 cmd_obs,
   output logic                                   pwr_req,
   input  logic                                   pwr_ack,
   output logic                                   obs_we,
   output logic [((N_OBS > 1) ? $clog2(N_OBS) : 1)-1:0] obs_addr,
   output logic [OBS_W-1:0]                       obs_data,
   output logic                                   mach_start,
   input  logic                                   mach_done,
   input  logic [RES_W-1:0]                       mach_result,
   output logic                                   rsp_valid,
   input  logic                                   rsp_ready,
   output logic [RES_W-1:0]                       rsp_result,
   output logic                                   rsp_timeout,
   output logic                                   busy,
   output logic [15:0]                            inf_count
);

   localparam int ADDR_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
   localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_OBS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PWR_UP,
      S_LOAD,
      S_START,
      S_WAIT,
      S_RESP,
      S_PWR_DN
   } state_t;

   state_t                   state, state_d;
   logic [N_OBS*OBS_W-1:0]   obs_q, obs_q_d;
   logic [TMO_W-1:0]         tmo_cnt, tmo_d;
   logic [ADDR_W-1:0]        next_addr;
   logic                     cmd_ready_d, pwr_req_d, obs_we_d, mach_start_d;
   logic                     rsp_valid_d, rsp_timeout_d, busy_d;
   logic [ADDR_W-1:0]        obs_addr_d;
   logic [OBS_W-1:0]         obs_data_d;
   logic [RES_W-1:0]         rsp_result_d;
   logic [15:0]              inf_count_d;

   // Every output is computed one cycle ahead here so that all of them leave the block registered.
   always_comb begin
      state_d       = state;
      obs_q_d       = obs_q;
      tmo_d         = tmo_cnt;
      cmd_ready_d   = cmd_ready;
      pwr_req_d     = pwr_req;
      obs_we_d      = 1'b0;
      obs_addr_d    = obs_addr;
      obs_data_d    = obs_data;
      mach_start_d  = 1'b0;
      rsp_valid_d   = rsp_valid;
      rsp_result_d  = rsp_result;
      rsp_timeout_d = rsp_timeout;
      busy_d        = busy;
      inf_count_d   = inf_count;
      next_addr     = obs_addr + ADDR_W'(1);

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               obs_q_d     = cmd_obs;
               pwr_req_d   = 1'b1;
               tmo_d       = '0;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = S_PWR_UP;
            end
         end
         S_PWR_UP: begin
            if (pwr_ack) begin
               obs_we_d   = 1'b1;
               obs_addr_d = '0;
               obs_data_d = obs_q[OBS_W-1:0];
               state_d    = S_LOAD;
            end else if (tmo_cnt == TMO_LAST) begin
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_result_d  = '0;
               state_d       = S_RESP;
            end else begin
               tmo_d = tmo_cnt + TMO_W'(1);
            end
         end
         S_LOAD: begin
            if (obs_addr == ADDR_LAST) begin
               mach_start_d = 1'b1;
               state_d      = S_START;
            end else begin
               obs_we_d   = 1'b1;
               obs_addr_d = next_addr;
               obs_data_d = obs_q[int'(next_addr)*OBS_W +: OBS_W];
            end
         end
         S_START: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         // A done on the last allowed cycle still counts as a real result.
         S_WAIT: begin
            if (mach_done) begin
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               rsp_result_d  = mach_result;
               state_d       = S_RESP;
            end else if (tmo_cnt == TMO_LAST) begin
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_result_d  = '0;
               state_d       = S_RESP;
            end else begin
               tmo_d = tmo_cnt + TMO_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               inf_count_d = inf_count + 16'd1;
               pwr_req_d   = 1'b0;
               state_d     = S_PWR_DN;
            end
         end
         S_PWR_DN: begin
            if (!pwr_ack) begin
               cmd_ready_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Reset drops the rail request immediately and discards any command or response in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         obs_q       <= '0;
         tmo_cnt     <= '0;
         cmd_ready   <= 1'b1;
         pwr_req     <= 1'b0;
         obs_we      <= 1'b0;
         obs_addr    <= '0;
         obs_data    <= '0;
         mach_start  <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_result  <= '0;
         rsp_timeout <= 1'b0;
         busy        <= 1'b0;
         inf_count   <= INF_COUNT_INIT;
      end else begin
         state       <= state_d;
         obs_q       <= obs_q_d;
         tmo_cnt     <= tmo_d;
         cmd_ready   <= cmd_ready_d;
         pwr_req     <= pwr_req_d;
         obs_we      <= obs_we_d;
         obs_addr    <= obs_addr_d;
         obs_data    <= obs_data_d;
         mach_start  <= mach_start_d;
         rsp_valid   <= rsp_valid_d;
         rsp_result  <= rsp_result_d;
         rsp_timeout <= rsp_timeout_d;
         busy        <= busy_d;
         inf_count   <= inf_count_d;
      end
   end

endmodule

// File: tb/tb_banzai_infer_sched.sv
// Directed bench for banzai_infer_sched: normal inference, both timeouts, response back-pressure,
// mid-operation reset and inf_count wrap (second instance starts its counter near the top).
module tb_banzai_infer_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [31:0] cmd_obs;
   logic        pwr_ack;
   logic        mach_done;
   logic [15:0] mach_result;
   logic        rsp_ready;

   logic        cmd_ready, pwr_req, obs_we, mach_start, rsp_valid, rsp_timeout, busy;
   logic [1:0]  obs_addr;
   logic [7:0]  obs_data;
   logic [15:0] rsp_result, inf_count;

   logic        w_cmd_ready, w_pwr_req, w_obs_we, w_mach_start, w_rsp_valid, w_rsp_timeout, w_busy;
   logic [1:0]  w_obs_addr;
   logic [7:0]  w_obs_data;
   logic [15:0] w_rsp_result, w_inf_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   banzai_infer_sched #(.N_OBS(4), .OBS_W(8), .RES_W(16), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_obs(cmd_obs),
      .pwr_req(pwr_req), .pwr_ack(pwr_ack), .obs_we(obs_we), .obs_addr(obs_addr),
      .obs_data(obs_data), .mach_start(mach_start), .mach_done(mach_done),
      .mach_result(mach_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy), .inf_count(inf_count)
   );

   // Shares all inputs with dut; only its counter is checked, which starts two below the wrap.
   banzai_infer_sched #(.N_OBS(4), .OBS_W(8), .RES_W(16), .TIMEOUT(16),
                        .INF_COUNT_INIT(16'hFFFE)) dut_wrap (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready), .cmd_obs(cmd_obs),
      .pwr_req(w_pwr_req), .pwr_ack(pwr_ack), .obs_we(w_obs_we), .obs_addr(w_obs_addr),
      .obs_data(w_obs_data), .mach_start(w_mach_start), .mach_done(mach_done),
      .mach_result(mach_result), .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(w_rsp_result), .rsp_timeout(w_rsp_timeout), .busy(w_busy),
      .inf_count(w_inf_count)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One complete inference with rail already up and done one cycle into WAIT.
   task automatic applyStimulus(input logic [31:0] obs);
      int n;
      pwr_ack   = 1'b1;
      cmd_obs   = obs;
      cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
      n = 0;
      while (mach_start !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput("stim_start_seen", {31'd0, mach_start}, 32'd1);
      tick(1);
      mach_done   = 1'b1;
      mach_result = 16'h0777;
      tick(1);
      mach_done = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput("stim_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      pwr_ack   = 1'b0;
      tick(1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic saw_we, saw_start, saw_early, unstable;

      rst = 1'b1; cmd_valid = 1'b0; cmd_obs = '0; pwr_ack = 1'b0;
      mach_done = 1'b0; mach_result = '0; rsp_ready = 1'b0;
      tick(2);
      rst = 1'b0;
      $display("[TB] reset state");
      checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("rst_busy",      {31'd0, busy},      32'd0);
      checkOutput("rst_pwr_req",   {31'd0, pwr_req},   32'd0);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst_result",    {16'd0, rsp_result}, 32'd0);
      checkOutput("rst_count",     {16'd0, inf_count}, 32'd0);
      checkOutput("rst_wrap_cnt",  {16'd0, w_inf_count}, 32'h0000FFFE);

      $display("[TB] normal inference");
      pwr_ack = 1'b1; cmd_obs = 32'h44332211; cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0; cmd_obs = 32'hDEADBEEF;
      checkOutput("t1_busy",      {31'd0, busy},      32'd1);
      checkOutput("t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("t1_pwr_req",   {31'd0, pwr_req},   32'd1);
      checkOutput("t1_no_we",     {31'd0, obs_we},    32'd0);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         checkOutput("t1_we",   {31'd0, obs_we},   32'd1);
         checkOutput("t1_addr", {30'd0, obs_addr}, 32'(i));
         checkOutput("t1_data", {24'd0, obs_data}, 32'((i + 1) * 17));
      end
      tick(1);
      checkOutput("t1_start",     {31'd0, mach_start}, 32'd1);
      checkOutput("t1_we_off",    {31'd0, obs_we},     32'd0);
      tick(1);
      checkOutput("t1_start_one", {31'd0, mach_start}, 32'd0);
      tick(4);
      checkOutput("t1_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
      mach_done = 1'b1; mach_result = 16'hBEEF;
      tick(1);
      mach_done = 1'b0; mach_result = '0;
      checkOutput("t1_rsp_valid", {31'd0, rsp_valid},   32'd1);
      checkOutput("t1_result",    {16'd0, rsp_result},  32'h0000BEEF);
      checkOutput("t1_timeout",   {31'd0, rsp_timeout}, 32'd0);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      checkOutput("t1_rsp_clear", {31'd0, rsp_valid}, 32'd0);
      checkOutput("t1_pwr_off",   {31'd0, pwr_req},   32'd0);
      checkOutput("t1_busy_dn",   {31'd0, busy},      32'd1);
      checkOutput("t1_count",     {16'd0, inf_count}, 32'd1);
      pwr_ack = 1'b0;
      tick(1);
      checkOutput("t1_idle_busy",  {31'd0, busy},      32'd0);
      checkOutput("t1_idle_ready", {31'd0, cmd_ready}, 32'd1);

      $display("[TB] power-up timeout");
      saw_we = 1'b0; saw_start = 1'b0; saw_early = 1'b0;
      cmd_obs = 32'h01020304; cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (obs_we) saw_we = 1'b1;
         if (mach_start) saw_start = 1'b1;
         if (rsp_valid) saw_early = 1'b1;
         if (c < 16) tick(1);
      end
      checkOutput("t2_no_we",    {31'd0, saw_we},    32'd0);
      checkOutput("t2_no_start", {31'd0, saw_start}, 32'd0);
      checkOutput("t2_no_early", {31'd0, saw_early}, 32'd0);
      tick(1);
      checkOutput("t2_rsp_valid", {31'd0, rsp_valid},   32'd1);
      checkOutput("t2_timeout",   {31'd0, rsp_timeout}, 32'd1);
      checkOutput("t2_result",    {16'd0, rsp_result},  32'd0);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      checkOutput("t2_count", {16'd0, inf_count}, 32'd2);
      tick(1);
      checkOutput("t2_idle", {31'd0, busy}, 32'd0);

      $display("[TB] wait timeout");
      pwr_ack = 1'b1; mach_result = 16'h1234; cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
      tick(1);
      mach_done = 1'b1;
      tick(1);
      mach_done = 1'b0;
      tick(3);
      checkOutput("t3a_start", {31'd0, mach_start}, 32'd1);
      tick(16);
      checkOutput("t3a_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
      tick(1);
      checkOutput("t3a_rsp_valid", {31'd0, rsp_valid},   32'd1);
      checkOutput("t3a_timeout",   {31'd0, rsp_timeout}, 32'd1);
      checkOutput("t3a_result",    {16'd0, rsp_result},  32'd0);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0; pwr_ack = 1'b0;
      tick(1);

      $display("[TB] done on final wait cycle");
      pwr_ack = 1'b1; cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
      tick(5);
      checkOutput("t3b_start", {31'd0, mach_start}, 32'd1);
      tick(16);
      mach_done = 1'b1; mach_result = 16'hCAFE;
      tick(1);
      mach_done = 1'b0; mach_result = '0;
      checkOutput("t3b_rsp_valid", {31'd0, rsp_valid},   32'd1);
      checkOutput("t3b_timeout",   {31'd0, rsp_timeout}, 32'd0);
      checkOutput("t3b_result",    {16'd0, rsp_result},  32'h0000CAFE);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      checkOutput("t3b_count", {16'd0, inf_count}, 32'd4);
      pwr_ack = 1'b0;
      tick(1);

      $display("[TB] response back-pressure with held command");
      pwr_ack = 1'b1; cmd_obs = 32'hA1B2C3D4; cmd_valid = 1'b1;
      tick(6);
      checkOutput("t4_start", {31'd0, mach_start}, 32'd1);
      tick(1);
      mach_done = 1'b1; mach_result = 16'h5A5A;
      tick(1);
      mach_done = 1'b0; mach_result = '0;
      checkOutput("t4_rsp_valid", {31'd0, rsp_valid},  32'd1);
      checkOutput("t4_result",    {16'd0, rsp_result}, 32'h00005A5A);
      unstable = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         if (rsp_valid !== 1'b1 || rsp_result !== 16'h5A5A || rsp_timeout !== 1'b0 ||
             cmd_ready !== 1'b0) unstable = 1'b1;
      end
      checkOutput("t4_rsp_stable", {31'd0, unstable}, 32'd0);
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      checkOutput("t4_dn_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("t4_count",    {16'd0, inf_count}, 32'd5);
      tick(2);
      checkOutput("t4_stuck_busy",  {31'd0, busy},      32'd1);
      checkOutput("t4_stuck_ready", {31'd0, cmd_ready}, 32'd0);
      pwr_ack = 1'b0;
      tick(1);
      checkOutput("t4_idle_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("t4_idle_busy",  {31'd0, busy},      32'd0);
      cmd_obs = 32'h0D0C0B0A;
      tick(1);
      cmd_valid = 1'b0; cmd_obs = 32'hFFFFFFFF;
      checkOutput("t4_second_busy", {31'd0, busy},    32'd1);
      checkOutput("t4_second_pwr",  {31'd0, pwr_req}, 32'd1);
      pwr_ack = 1'b1;
      tick(1);
      checkOutput("t4_second_we",   {31'd0, obs_we},   32'd1);
      checkOutput("t4_second_data", {24'd0, obs_data}, 32'h0000000A);

      $display("[TB] reset during load");
      rst = 1'b1;
      tick(1);
      rst = 1'b0; pwr_ack = 1'b0;
      checkOutput("t5_pwr_req",   {31'd0, pwr_req},   32'd0);
      checkOutput("t5_obs_we",    {31'd0, obs_we},    32'd0);
      checkOutput("t5_busy",      {31'd0, busy},      32'd0);
      checkOutput("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("t5_count",     {16'd0, inf_count}, 32'd0);
      tick(1);
      checkOutput("t5_stays_idle", {31'd0, busy}, 32'd0);

      $display("[TB] counter wrap");
      applyStimulus(32'h11111111);
      checkOutput("t6_count1", {16'd0, inf_count},   32'd1);
      checkOutput("t6_wrap1",  {16'd0, w_inf_count}, 32'h0000FFFF);
      applyStimulus(32'h22222222);
      checkOutput("t6_count2", {16'd0, inf_count},   32'd2);
      checkOutput("t6_wrap2",  {16'd0, w_inf_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
